// File: rtl/mult_div_unit.sv
// mult_div_unit
//   Execute-stage multiply/divide unit. It holds the HI/LO architectural
//   registers and services MTHI/MTLO writes. MULT/MULTU/DIV/DIVU results are
//   computed and latched into a pending pair at the start edge. They are then
//   committed to HI/LO when a countdown busy window expires.
//
// Ports
//   clk    in   1   rising-edge clock
//   reset  in   1   asynchronous, active-high reset
//   A      in   32  rs operand: multiplicand / dividend / MTHI-MTLO data
//   B      in   32  rt operand: multiplier / divisor
//   MDUOp  in   3   0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO,
//                   7 reserved (no effect)
//   Start  in   1   qualifies MDUOp this cycle
//   HI     out  32  HI register
//   LO     out  32  LO register
//   Busy   out  1   multi-cycle operation in flight (registered)
//
// Handshake: Start is a one-cycle request that is valid together with MDUOp.
// It is accepted only on an edge where Busy is low. A Start seen while Busy is
// high is dropped without any state change. Nothing is queued, so upstream must
// stall on Start | Busy.
module mult_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [2:0]  MDUOp,
  input  logic        Start,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic        Busy
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6,
    OP_RSVD  = 3'd7
  } op_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  logic [CW-1:0] count, count_nxt;
  logic [31:0]   hi_pend, lo_pend, hi_pend_nxt, lo_pend_nxt;
  logic [31:0]   hi_nxt, lo_nxt;
  logic          skip, skip_nxt;
  state_e        state;

  // The countdown register is the state: any nonzero count means RUN.
  assign state = (count != '0) ? RUN : IDLE;
  assign Busy  = (state == RUN);

  // Products. The signed product uses explicitly sign-extended 64-bit operands
  // so that the low 64 bits of the multiply are the true signed result.
  logic [63:0] prod_s, prod_u;
  assign prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
  assign prod_u = {32'b0, A} * {32'b0, B};

  // A single unsigned divider is shared by DIV and DIVU. For DIV, the operands
  // are made magnitudes and the signs are fixed up afterwards. The quotient
  // sign is the XOR of the operand signs. The remainder takes the sign of the
  // dividend. For 0x80000000 / -1, the magnitudes 0x80000000 / 1 give quotient
  // 0x80000000 with positive sign, which is the required wrap. A zero divisor
  // is replaced by 1 so that the divider never sees 0. The result is discarded
  // through skip in that case.
  logic        div_signed, neg_a, neg_b;
  logic [31:0] dvd, dvs, quo_u, rem_u, quo, rem;
  assign div_signed = (MDUOp == OP_DIV);
  assign neg_a      = div_signed & A[31];
  assign neg_b      = div_signed & B[31];
  assign dvd        = neg_a ? (32'd0 - A) : A;
  assign dvs        = (B == 32'd0) ? 32'd1 : (neg_b ? (32'd0 - B) : B);
  assign quo_u      = dvd / dvs;
  assign rem_u      = dvd % dvs;
  assign quo        = (neg_a ^ neg_b) ? (32'd0 - quo_u) : quo_u;
  assign rem        = neg_a ? (32'd0 - rem_u) : rem_u;

  always_comb begin
    count_nxt   = count;
    hi_nxt      = HI;
    lo_nxt      = LO;
    hi_pend_nxt = hi_pend;
    lo_pend_nxt = lo_pend;
    skip_nxt    = skip;
    case (state)
      IDLE: begin
        if (Start) begin
          case (MDUOp)
            OP_MULT: begin
              {hi_pend_nxt, lo_pend_nxt} = prod_s;
              skip_nxt  = 1'b0;
              count_nxt = CW'(MULT_CYCLES);
            end
            OP_MULTU: begin
              {hi_pend_nxt, lo_pend_nxt} = prod_u;
              skip_nxt  = 1'b0;
              count_nxt = CW'(MULT_CYCLES);
            end
            OP_DIV, OP_DIVU: begin
              hi_pend_nxt = rem;
              lo_pend_nxt = quo;
              skip_nxt    = (B == 32'd0);
              count_nxt   = CW'(DIV_CYCLES);
            end
            OP_MTHI: hi_nxt = A;
            OP_MTLO: lo_nxt = A;
            default: ;
          endcase
        end
      end
      RUN: begin
        count_nxt = count - 1'b1;
        if ((count == CW'(1)) && !skip) begin
          hi_nxt = hi_pend;
          lo_nxt = lo_pend;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count   <= '0;
      HI      <= '0;
      LO      <= '0;
      hi_pend <= '0;
      lo_pend <= '0;
      skip    <= 1'b0;
    end else begin
      count   <= count_nxt;
      HI      <= hi_nxt;
      LO      <= lo_nxt;
      hi_pend <= hi_pend_nxt;
      lo_pend <= lo_pend_nxt;
      skip    <= skip_nxt;
    end
  end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Multiply/divide unit for the execute stage, sitting beside the ALU and fed from the same operand path (A = rs value, B = rt value after forwarding). Performs MULT/MULTU/DIV/DIVU as multi-cycle operations with a countdown busy window, holds the HI/LO architectural registers, and services MTHI/MTLO writes. MFHI/MFLO read HI/LO directly. The hazard unit stalls decode on `Start | Busy` when the instruction in decode uses HI/LO.

## Interface
- `MULT_CYCLES`, default 5: busy cycles for MULT/MULTU.
- `DIV_CYCLES`, default 10: busy cycles for DIV/DIVU.
- `clk`  in  1  system clock, rising-edge.
- `reset`  in  1  asynchronous, active-high reset.
- `A`  in  32  operand 1 (rs): dividend / multiplicand / MTHI-MTLO data.
- `B`  in  32  operand 2 (rt): divisor / multiplier.
- `MDUOp`  in  3  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (treated as NONE).
- `Start`  in  1  qualifies `MDUOp` this cycle.
- `HI`  out  32  HI register.
- `LO`  out  32  LO register.
- `Busy`  out  1  multi-cycle operation in flight.

## Operation
- Registers: `HI`, `LO`, `count` (width ≥ clog2(max(MULT_CYCLES,DIV_CYCLES)+1)), `hi_pend`, `lo_pend`, `skip` (div-by-zero flag).
- Two states, IDLE (`count==0`) and RUN (`count!=0`). `Busy = (count != 0)`, registered state only.
- IDLE, `Start=1`:
  - MULT: `{hi_pend,lo_pend} = $signed(A) * $signed(B)` (64-bit); `count ← MULT_CYCLES`.
  - MULTU: unsigned 64-bit product; `count ← MULT_CYCLES`.
  - DIV: `lo_pend = $signed(A)/$signed(B)` (truncate toward zero), `hi_pend = $signed(A)%$signed(B)` (sign of dividend); `count ← DIV_CYCLES`.
  - DIVU: unsigned quotient/remainder; `count ← DIV_CYCLES`.
  - MTHI: `HI ← A` at this edge, no busy window. MTLO: `LO ← A` likewise.
  - NONE/reserved: no effect.
- Results are computed and latched at the start edge; `A`/`B` may change afterwards without effect.
- RUN: `count` decrements each edge; on the edge where `count` goes 1→0, `HI ← hi_pend`, `LO ← lo_pend` (unless `skip`).
- Divide by zero (`B==0`, DIV or DIVU): full busy window runs, `skip=1`, HI/LO retain prior values.
- Signed overflow DIV 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0x00000000.
- `Start` while `Busy=1` (any op, including MTHI/MTLO): ignored, no state change. Upstream stalls prevent this; the unit does not queue.

## Timing
- Reset (async, any time): `HI=0`, `LO=0`, `count=0`, `Busy=0`, pending/skip cleared. Reset mid-operation aborts it; no late HI/LO write after reset release.
- Start sampled at edge t with `Busy=0`: `Busy=1` for cycles t+1 … t+N (N = MULT_CYCLES or DIV_CYCLES); HI/LO update at edge t+N, `Busy=0` in the same cycle the new HI/LO appear.
- Back-to-back: new `Start` accepted at edge t+N (`Busy` still 1 before that edge) is ignored; first acceptable edge is t+N+1... no: acceptance requires `Busy=0` as sampled, i.e. edge t+N+1 at the earliest.
- MTHI/MTLO: HI/LO visible the cycle after the start edge; `Busy` stays 0.
- HI/LO are register outputs; no combinational path from `A`, `B`, `MDUOp`, `Start` to any output.

## Test plan
- MULT A=0xFFFFFFFF, B=0x00000002, Start 1 cycle -> Busy high exactly 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE.
- MULTU same operands -> after 5 cycles HI=0x00000001, LO=0xFFFFFFFE; DIV A=0xFFFFFFF9 (-7), B=2 -> Busy 10 cycles, LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU A=7, B=0 with HI=0x11111111, LO=0x22222222 preloaded via MTHI/MTLO -> Busy 10 cycles, HI/LO unchanged; DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- MULT started, then Start with MTLO A=0xDEADBEEF on cycle 2 of busy -> MTLO ignored, LO ends as product; MTLO after Busy falls -> LO=0xDEADBEEF next cycle.
- Reset asserted asynchronously mid-DIV (cycle 4) -> HI=LO=0, Busy=0 immediately; after release no HI/LO change for 20 idle cycles.
- Operands changed every cycle during a MULTU window -> result equals product of operands at the start edge only.
